// File: rtl/key_step_pkg.sv
// Shared types and default constants for the single-step key conditioner.
// Optional auto-run build is selected with KEY_STEP_AUTO_EN.
package key_step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DB_PRESS = 2'd1,
        ST_HELD     = 2'd2,
        ST_DB_REL   = 2'd3
    } key_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;   // 10 ms at 50 MHz
    localparam int DEFAULT_CNT_W           = 16;
    localparam int DEFAULT_AUTO_DIV        = 25000000; // 0.5 s at 50 MHz

endpackage

// File: rtl/key_step_ctrl_if.sv
// Key / step bundle between the board-level key and the step consumer.
// auto_run exists only when KEY_STEP_AUTO_EN is defined.
interface key_step_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             key_n;
    logic             step;
    logic [CNT_W-1:0] step_count;
    logic             key_held;
`ifdef KEY_STEP_AUTO_EN
    logic             auto_run;

    modport slave  (input  key_n, auto_run, output step, step_count, key_held);
    modport master (output key_n, auto_run, input  step, step_count, key_held);
`else
    modport slave  (input  key_n, output step, step_count, key_held);
    modport master (output key_n, input  step, step_count, key_held);
`endif
endinterface

// File: rtl/key_step_ctrl_sync_2ff.sv
// Single-bit two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic ff1_q;
    logic ff2_q;

    // NOTE: resetting to the idle level keeps downstream logic from seeing a false edge out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ff1_q <= RESET_VAL;
            ff2_q <= RESET_VAL;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/key_step_ctrl.sv
// Push-button conditioner: synchronizer, debounce FSM and one-shot step strobe with a step counter.
// Define KEY_STEP_AUTO_EN to add the auto_run periodic step generator.
module key_step_ctrl
    import key_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
`ifdef KEY_STEP_AUTO_EN
    ,
    parameter int AUTO_DIV        = DEFAULT_AUTO_DIV
`endif
) (
    input logic            clk,
    input logic            reset,
    key_step_ctrl_if.slave bus
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    // The entry cycle into a debounce state is the first stable sample, so the last count is N-2.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 2);

    logic             key_s;
    key_state_e       state_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic             key_held_q;
    logic             press_q;
    logic             step_d;
    logic             step_q;
    logic [CNT_W-1:0] step_count_q;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  (bus.key_n),
        .q_o  (key_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            db_cnt_q   <= '0;
            key_held_q <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!key_s) begin
                        state_q  <= ST_DB_PRESS;
                        db_cnt_q <= '0;
                    end
                end
                ST_DB_PRESS: begin
                    if (key_s) begin
                        state_q <= ST_IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q    <= ST_HELD;
                        key_held_q <= 1'b1;
                        press_q    <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                ST_HELD: begin
                    if (key_s) begin
                        state_q  <= ST_DB_REL;
                        db_cnt_q <= '0;
                    end
                end
                ST_DB_REL: begin
                    if (!key_s) begin
                        state_q <= ST_HELD;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q    <= ST_IDLE;
                        key_held_q <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef KEY_STEP_AUTO_EN
    localparam int               DIV_W    = $clog2(AUTO_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             auto_fire;

    assign auto_fire = bus.auto_run && (div_q == DIV_LAST);

    // Held at zero while auto_run is low, so the first pulse lands AUTO_DIV cycles after it rises.
    always_ff @(posedge clk) begin
        if (reset || !bus.auto_run || auto_fire) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign step_d = auto_fire | (press_q & ~bus.auto_run);
`else
    assign step_d = press_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q       <= 1'b0;
            step_count_q <= '0;
        end else begin
            step_q <= step_d;
            if (step_d) begin
                step_count_q <= step_count_q + CNT_W'(1);
            end
        end
    end

    assign bus.step       = step_q;
    assign bus.step_count = step_count_q;
    assign bus.key_held   = key_held_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
// Directed bench for key_step_ctrl with a step scoreboard (expected cycle and count per pulse).
// Auto-run scenario is compiled in only when KEY_STEP_AUTO_EN is defined.
module tb_key_step_ctrl;

    localparam int CNT_W   = 4;
    localparam int DB      = 4;
    localparam int LATENCY = 2 + DB + 1;

    typedef struct {
        int               cyc;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    int               cyc = 0;
    int               n_tests = 0;
    int               n_fail = 0;
    int               n_steps = 0;
    logic [CNT_W-1:0] exp_count = '0;
    exp_t             sb[$];

    key_step_ctrl_if #(.CNT_W(CNT_W)) bus ();

    key_step_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CNT_W)
`ifdef KEY_STEP_AUTO_EN
        ,
        .AUTO_DIV       (8)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every step pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.step === 1'b1) begin
            n_steps++;
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_step: step high at cycle %0d, expected no step", cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("step_cycle", 32'(cyc), 32'(e.cyc));
                check("step_count_at_step", 32'(bus.step_count), 32'(e.cnt));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_step(input int delay);
        exp_count = exp_count + CNT_W'(1);
        sb.push_back('{cyc: cyc + delay, cnt: exp_count});
    endtask

    task automatic press(input int low, input int high);
        bus.key_n = 1'b0;
        expect_step(LATENCY);
        tick(low);
        bus.key_n = 1'b1;
        tick(high);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick(1);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_step"}, 32'(bus.step), 32'd0);
        check({tag, "_count"}, 32'(bus.step_count), 32'd0);
        check({tag, "_held"}, 32'(bus.key_held), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        check_reset_outputs("pulse_reset");
        reset = 1'b0;
        exp_count = '0;
        tick(2);
    endtask

    initial begin
        int c;
        int steps_before;
        reset     = 1'b1;
        bus.key_n = 1'b1;
`ifdef KEY_STEP_AUTO_EN
        bus.auto_run = 1'b0;
`endif

        // Reset held for three cycles, key released.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_reset_outputs("reset_hold");
        end
        reset = 1'b0;
        tick(2);

        // Clean press: step 7 cycles after the fall, key_held drops 6 cycles after release.
        bus.key_n = 1'b0;
        expect_step(LATENCY);
        tick(DB + 1);
        check("held_before_debounce", 32'(bus.key_held), 32'd0);
        tick(1);
        check("held_after_debounce", 32'(bus.key_held), 32'd1);
        tick(14);
        bus.key_n = 1'b1;
        tick(5);
        check("held_during_release", 32'(bus.key_held), 32'd1);
        tick(1);
        check("held_dropped", 32'(bus.key_held), 32'd0);
        drain("clean_press_drain");
        check("clean_press_count", 32'(bus.step_count), 32'd1);

        // Bounce: 2-cycle toggles starting low, then stable low.
        for (int seg = 0; seg < 6; seg++) begin
            bus.key_n = seg[0];
            tick(2);
        end
        bus.key_n = 1'b0;
        expect_step(LATENCY);
        tick(12);
        bus.key_n = 1'b1;
        tick(10);
        drain("bounce_drain");
        check("bounce_count", 32'(bus.step_count), 32'd2);

        // Seventeen presses from a fresh reset: count wraps 15 -> 0 -> 1.
        pulse_reset();
        steps_before = n_steps;
        for (int i = 0; i < 17; i++) begin
            press(10, 10);
            if (i == 14) check("count_at_15", 32'(bus.step_count), 32'd15);
            if (i == 15) check("count_wrapped", 32'(bus.step_count), 32'd0);
        end
        drain("multi_press_drain");
        check("multi_press_count", 32'(bus.step_count), 32'd1);
        check("multi_press_pulses", 32'(n_steps - steps_before), 32'd17);

        // Reset while HELD: outputs clear next cycle, no step until a fresh press.
        bus.key_n = 1'b0;
        expect_step(LATENCY);
        tick(10);
        check("held_before_reset", 32'(bus.key_held), 32'd1);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("reset_in_held");
        bus.key_n = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_count = '0;
        tick(15);
        check("after_held_reset_count", 32'(bus.step_count), 32'd0);
        press(10, 10);
        drain("repress_after_held_reset");
        check("repress_after_held_count", 32'(bus.step_count), 32'd1);

        // Reset while DB_PRESS: the press in flight is abandoned.
        bus.key_n = 1'b0;
        tick(DB);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("reset_in_db_press");
        bus.key_n = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_count = '0;
        tick(15);
        check("after_dbp_reset_count", 32'(bus.step_count), 32'd0);
        press(10, 10);
        drain("repress_after_dbp_reset");
        check("repress_after_dbp_count", 32'(bus.step_count), 32'd1);

`ifdef KEY_STEP_AUTO_EN
        // Auto-run for 40 cycles with a key press inside: five auto steps, no key step.
        pulse_reset();
        steps_before = n_steps;
        bus.auto_run = 1'b1;
        c = cyc;
        for (int k = 1; k <= 5; k++) begin
            exp_count = exp_count + CNT_W'(1);
            sb.push_back('{cyc: c + 8 * k, cnt: exp_count});
        end
        tick(5);
        bus.key_n = 1'b0;
        tick(10);
        check("auto_key_held", 32'(bus.key_held), 32'd1);
        bus.key_n = 1'b1;
        tick(25);
        bus.auto_run = 1'b0;
        tick(10);
        drain("auto_drain");
        check("auto_count", 32'(bus.step_count), 32'd5);
        check("auto_pulses", 32'(n_steps - steps_before), 32'd5);
        check("auto_key_released", 32'(bus.key_held), 32'd0);
`endif

        tick(5);
        check("final_scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
